// File: rtl/seg_scan_if.sv
// seg_scan_if: per-digit segment patterns and brightness in, scanned segment/anode bus out.
// Blink mask present only when BLINK_SEG_EN is defined.
interface seg_scan_if;
  logic [6:0] seg0_in, seg1_in, seg2_in, seg3_in, seg4_in, seg5_in;
  logic [2:0] bright;
`ifdef BLINK_SEG_EN
  logic [5:0] blink_mask;
`endif
  logic [6:0] seg_n;
  logic [5:0] an_n;
  logic [2:0] digit_idx;
  logic       frame_start;
  modport master (
`ifdef BLINK_SEG_EN
    output blink_mask,
`endif
    output seg0_in, seg1_in, seg2_in, seg3_in, seg4_in, seg5_in, bright,
    input  seg_n, an_n, digit_idx, frame_start
  );
  modport slave (
`ifdef BLINK_SEG_EN
    input  blink_mask,
`endif
    input  seg0_in, seg1_in, seg2_in, seg3_in, seg4_in, seg5_in, bright,
    output seg_n, an_n, digit_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 6-digit common-anode 7-seg scanner with blanking, PWM brightness, frame snapshots.
// Optional per-digit blinking under BLINK_SEG_EN.
module seg_scan_driver #(
  parameter int SCAN_LOG2    = 10,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 64
) (
  input logic      clk,
  input logic      reset,
  seg_scan_if.slave bus
);
  localparam logic [SCAN_LOG2-1:0] BLANK = SCAN_LOG2'(BLANK_CYC);
  logic [SCAN_LOG2-1:0] cnt;
  logic [2:0] digit, bright_sh;
  logic [6:0] sh [6];
  logic [6:0] in_seg [6];
  logic wrap, frame_end, lit, blink_off;
  assign in_seg[0] = bus.seg0_in;
  assign in_seg[1] = bus.seg1_in;
  assign in_seg[2] = bus.seg2_in;
  assign in_seg[3] = bus.seg3_in;
  assign in_seg[4] = bus.seg4_in;
  assign in_seg[5] = bus.seg5_in;
  assign wrap      = &cnt;
  assign frame_end = wrap && digit == 3'd5;
`ifdef BLINK_SEG_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic [5:0] mask_sh;
  logic phase, fc_last;
  assign fc_last   = fcnt == FW'(BLINK_FRAMES - 1);
  assign blink_off = phase && mask_sh[digit];
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt    <= '0;
      phase   <= 1'b0;
      mask_sh <= '0;
    end else if (frame_end) begin
      mask_sh <= bus.blink_mask;
      fcnt    <= fc_last ? '0 : fcnt + 1'b1;
      phase   <= phase ^ fc_last;
    end
  end
`else
  assign blink_off = 1'b0;
`endif
  // PWM window: lit only once the slot's top three count bits reach 7 - bright
  assign lit = cnt >= BLANK && cnt[SCAN_LOG2-1 -: 3] >= 3'd7 - bright_sh && !blink_off;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      digit           <= '0;
      bright_sh       <= 3'd7;
      sh              <= '{default: 7'h7F};
      bus.an_n        <= 6'h3F;
      bus.seg_n       <= 7'h7F;
      bus.digit_idx   <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      cnt             <= cnt + 1'b1;
      digit           <= wrap ? (digit == 3'd5 ? 3'd0 : digit + 3'd1) : digit;
      sh              <= frame_end ? in_seg : sh;
      bright_sh       <= frame_end ? bus.bright : bright_sh;
      bus.an_n        <= lit ? ~(6'b1 << digit) : 6'h3F;
      bus.seg_n       <= lit ? sh[digit] : 7'h7F;
      bus.digit_idx   <= digit;
      bus.frame_start <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench; expected outputs derived from scan position arithmetic.
module tb_seg_scan_driver;
  localparam int SL = 4, BC = 2, BF = 2;
  localparam int SLOT = 1 << SL, FRAME = 6 * SLOT;
  typedef struct packed {
    logic [6:0] seg;
    logic [5:0] an;
    logic [2:0] idx;
    logic       fs;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  seg_scan_if bus();
  seg_scan_driver #(.SCAN_LOG2(SL), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [6:0] segs [6];
  logic [2:0] bright;
  logic [5:0] mask;
  logic [6:0] m_seg [6];
  int m_bright, k;
  logic [5:0] m_mask;

  // q = cycles since reset release whose scan state the outputs show
  function automatic exp_t model_out(int q);
    exp_t e;
    int c, d, f;
    bit blink, lit;
    c = q % SLOT;
    d = (q / SLOT) % 6;
    f = q / FRAME;
    blink = ((f / BF) % 2 == 1) && m_mask[d];
    lit = c >= BC && (c * 8) / SLOT >= 7 - m_bright && !blink;
    e.seg = lit ? m_seg[d] : 7'h7F;
    e.an = 6'h3F;
    if (lit) e.an[d] = 1'b0;
    e.idx = 3'(d);
    e.fs = 1'b0;
    return e;
  endfunction

  task automatic cyc(input bit r);
    exp_t e;
    bus.seg0_in = segs[0]; bus.seg1_in = segs[1]; bus.seg2_in = segs[2];
    bus.seg3_in = segs[3]; bus.seg4_in = segs[4]; bus.seg5_in = segs[5];
    bus.bright = bright;
`ifdef BLINK_SEG_EN
    bus.blink_mask = mask;
`endif
    reset = r;
    if (r) begin
      e = '{seg: 7'h7F, an: 6'h3F, idx: 3'd0, fs: 1'b0};
      k = 0;
      foreach (m_seg[i]) m_seg[i] = 7'h7F;
      m_bright = 7;
      m_mask = '0;
    end else begin
      k++;
      e = model_out(k - 1);
      e.fs = (k % FRAME) == 0;
      if ((k - 1) % FRAME == FRAME - 1) begin
        foreach (m_seg[i]) m_seg[i] = segs[i];
        m_bright = int'(bright);
`ifdef BLINK_SEG_EN
        m_mask = mask;
`endif
      end
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int chg);
    for (int i = 0; i < n; i++) begin
      if (chg > 0 && $urandom_range(0, chg) == 0) segs[$urandom_range(0, 5)] = 7'($urandom);
      if (chg > 0 && $urandom_range(0, 8 * chg) == 0) bright = 3'($urandom);
      if (chg > 0 && $urandom_range(0, 8 * chg) == 0) mask = 6'($urandom);
      cyc(1'b0);
    end
  endtask

  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = '{seg: bus.seg_n, an: bus.an_n, idx: bus.digit_idx, fs: bus.frame_start};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL scan t=%0t: got seg_n=%h an_n=%h idx=%0d fs=%b, want seg_n=%h an_n=%h idx=%0d fs=%b",
                   $time, got.seg, got.an, got.idx, got.fs, e.seg, e.an, e.idx, e.fs);
        end
      end
    end
  end

  initial begin
    foreach (segs[i]) segs[i] = 7'($urandom);
    segs[0] = 7'b0000001;
    bright = 3'd7;
    mask = 6'b000001;
    repeat (3) cyc(1'b1);
    run(2 * FRAME, 0);
    bright = 3'd0;
    run(2 * FRAME, 0);
    bright = 3'd7;
    run(FRAME + 3 * SLOT + 5, 0);
    segs[3] = ~segs[3];
    run(FRAME, 0);
    run(10 * FRAME, 20);
    while (k % FRAME < 4 * SLOT || k % FRAME >= 5 * SLOT) cyc(1'b0);
    run(3, 0);
    cyc(1'b1);
    cyc(1'b1);
    run(2 * FRAME + 7, 15);
    cyc(1'b1);
    run(8 * FRAME, 25);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
